// File: rtl/deser32_pkg.sv
// Shared constants and state encoding for the deser32 serial-to-parallel collector.
package deser32_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CW_DEF    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/deser32_bit_counter.sv
// Bit counter for deser32: synchronous clear/enable, with terminal-count flag
// raised when the counter sits on the final bit position (WIDTH-1).
module bit_counter #(
    parameter int CW    = 5,
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    // Count qualified bits; clear has priority over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/deser32.sv
// deser32: collects WIDTH serial bits (LSB first) into a parallel word and
// pulses done for one cycle when the word is complete.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; bit_en/sin/abort ignored
// ST_SHIFT | sampling sin on each bit_en; abort returns to IDLE
// ST_DONE  | word just loaded; done high for this single cycle
module deser32
    import deser32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_en,
    input  logic             sin,
    input  logic             abort,
    output logic [WIDTH-1:0] word,
    output logic             done,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shift;
    logic             tc;
    logic             in_idle;
    logic             in_shift;
    logic             take_bit;
    logic             last_bit;
    logic             cnt_clr;

    assign in_idle     = (state == ST_IDLE);
    assign in_shift    = (state == ST_SHIFT);
    assign shreg_shift = {sin, shreg[WIDTH-1:1]};

    // Abort wins over a coincident bit, so a cancelled final bit never loads word.
    assign take_bit = in_shift && bit_en && !abort;
    assign last_bit = take_bit && tc;
    assign cnt_clr  = (in_idle && start) || (in_shift && abort) || last_bit;

    bit_counter #(
        .CW    (CW),
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (take_bit),
        .cnt (bit_cnt),
        .tc  (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (bit_en && tc) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decode straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Shift register: cleared at capture start, shifts right on each accepted bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (in_idle && start) begin
            shreg <= '0;
        end else if (take_bit) begin
            shreg <= shreg_shift;
        end
    end

    // Output word only updates on the completing bit, so partial words never show.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
        end else if (last_bit) begin
            word <= shreg_shift;
        end
    end

endmodule

// File: tb/tb_deser32.sv
// Self-checking bench for deser32: per-scenario tasks plus a done-driven
// scoreboard that pops expected words as the DUT completes them.
module tb_deser32;

    logic        clk;
    logic        rst;
    logic        start;
    logic        bit_en;
    logic        sin;
    logic        abort;
    logic [31:0] word;
    logic        done;
    logic        busy;
    logic [4:0]  bit_cnt;

    int          n_cmp;
    int          n_err;
    int          done_cnt;
    int          n_push;
    logic [31:0] exp_q[$];
    logic [31:0] last_word;
    logic [31:0] prev_word;

    deser32 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bit_en  (bit_en),
        .sin     (sin),
        .abort   (abort),
        .word    (word),
        .done    (done),
        .busy    (busy),
        .bit_cnt (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every done pops one expected word; word must not move otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            prev_word = word;
        end else begin
            if (done) begin
                done_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected_done: word=%h with no expected word queued", word);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (word !== e) begin
                        n_err++;
                        $display("FAIL sb_word: got %h expected %h", word, e);
                    end
                end
            end
            n_cmp++;
            if (word !== prev_word && !done) begin
                n_err++;
                $display("FAIL word_stable: word changed %h -> %h without done", prev_word, word);
            end
            prev_word = word;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            start  = 1'($urandom);
            bit_en = 1'($urandom);
            sin    = 1'($urandom);
            abort  = 1'($urandom);
            n_cmp++;
            if ({word, done, busy, bit_cnt} !== 39'd0) begin
                n_err++;
                $display("FAIL reset_outputs: word=%h done=%b busy=%b bit_cnt=%0d expected all 0",
                         word, done, busy, bit_cnt);
            end
        end
        start = 0; bit_en = 0; sin = 0; abort = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] w;
        int d0;
        w = 32'h0000_0fff;
        exp_q.push_back(w); n_push++;
        d0 = done_cnt;
        do_start();
        n_cmp++;
        if (busy !== 1'b1 || bit_cnt !== 5'd0) begin
            n_err++;
            $display("FAIL basic_enter: busy=%b bit_cnt=%0d expected 1 0", busy, bit_cnt);
        end
        for (int i = 0; i < 32; i++) begin
            sin = w[i]; bit_en = 1'b1;
            @(posedge clk); #1;
            if (i < 31) begin
                n_cmp++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL basic_early: bit %0d done=%b busy=%b expected 0 1", i, done, busy);
                end
            end
        end
        bit_en = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || word !== w) begin
            n_err++;
            $display("FAIL basic_done: done=%b busy=%b word=%h expected 1 0 %h", done, busy, word, w);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_after: done=%b busy=%b expected 0 0", done, busy);
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_err++;
            $display("FAIL basic_pulses: got %0d done pulses expected 1", done_cnt - d0);
        end
        last_word = w;
    endtask

    task automatic test_gapped();
        logic [31:0] w;
        int i;
        int cyc;
        w = 32'hA5A5_3C3C;
        exp_q.push_back(w); n_push++;
        do_start();
        i = 0; cyc = 0;
        while (i < 32) begin
            if (cyc % 3 == 2) begin
                bit_en = 1'b0; sin = 1'($urandom);
                @(posedge clk); #1;
                n_cmp++;
                if (bit_cnt !== 5'(i) || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL gap_hold: bit_cnt=%0d busy=%b expected %0d 1", bit_cnt, busy, i);
                end
            end else begin
                n_cmp++;
                if (bit_cnt !== 5'(i)) begin
                    n_err++;
                    $display("FAIL gap_count: bit_cnt=%0d expected %0d", bit_cnt, i);
                end
                sin = w[i]; bit_en = 1'b1;
                @(posedge clk); #1;
                i++;
            end
            cyc++;
        end
        bit_en = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || word !== w) begin
            n_err++;
            $display("FAIL gap_done: done=%b word=%h expected 1 %h", done, word, w);
        end
        @(posedge clk); #1;
        last_word = w;
    endtask

    task automatic test_abort_last();
        do_start();
        for (int i = 0; i < 31; i++) begin
            sin = 1'b1; bit_en = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bit_cnt !== 5'd31) begin
            n_err++;
            $display("FAIL abort_pre: bit_cnt=%0d expected 31", bit_cnt);
        end
        sin = 1'b1; bit_en = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; bit_en = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || bit_cnt !== 5'd0 || word !== last_word) begin
            n_err++;
            $display("FAIL abort_last: done=%b busy=%b bit_cnt=%0d word=%h expected 0 0 0 %h",
                     done, busy, bit_cnt, word, last_word);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_after: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_stray_controls();
        logic [31:0] w;
        w = 32'h0F1E_2D3C;
        exp_q.push_back(w); n_push++;
        do_start();
        for (int i = 0; i < 32; i++) begin
            sin = w[i]; bit_en = 1'b1;
            start = (i == 5 || i == 6);
            @(posedge clk); #1;
            if (i < 31) begin
                n_cmp++;
                if (bit_cnt !== 5'(i + 1)) begin
                    n_err++;
                    $display("FAIL stray_count: bit_cnt=%0d expected %0d", bit_cnt, i + 1);
                end
            end
        end
        bit_en = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || word !== w) begin
            n_err++;
            $display("FAIL stray_done: done=%b word=%h expected 1 %h", done, word, w);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL stray_start_in_done: busy=%b done=%b expected 0 0", busy, done);
        end
        for (int c = 0; c < 8; c++) begin
            bit_en = 1'($urandom); sin = 1'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (word !== w || busy !== 1'b0) begin
                n_err++;
                $display("FAIL stray_idle: word=%h busy=%b expected %h 0", word, busy, w);
            end
        end
        bit_en = 1'b0; sin = 1'b0;
        last_word = w;
    endtask

    task automatic test_async_reset();
        logic [31:0] w;
        w = 32'h1234_5678;
        do_start();
        for (int i = 0; i < 10; i++) begin
            sin = 1'($urandom); bit_en = 1'b1;
            @(posedge clk); #1;
        end
        bit_en = 1'b0;
        n_cmp++;
        if (bit_cnt !== 5'd10) begin
            n_err++;
            $display("FAIL areset_pre: bit_cnt=%0d expected 10", bit_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({word, done, busy, bit_cnt} !== 39'd0) begin
            n_err++;
            $display("FAIL areset_immediate: word=%h done=%b busy=%b bit_cnt=%0d expected all 0",
                     word, done, busy, bit_cnt);
        end
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        exp_q.push_back(w); n_push++;
        do_start();
        for (int i = 0; i < 32; i++) begin
            sin = w[i]; bit_en = 1'b1;
            @(posedge clk); #1;
        end
        bit_en = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || word !== w) begin
            n_err++;
            $display("FAIL areset_recapture: done=%b word=%h expected 1 %h", done, word, w);
        end
        @(posedge clk); #1;
        last_word = w;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; done_cnt = 0; n_push = 0;
        last_word = '0; prev_word = '0;
        rst = 1'b0; start = 0; bit_en = 0; sin = 0; abort = 0;

        test_reset();
        test_basic();
        test_gapped();
        test_abort_last();
        test_stray_controls();
        test_async_reset();

        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() !== 0 || done_cnt !== n_push) begin
            n_err++;
            $display("FAIL sb_drain: %0d words left, %0d done pulses expected %0d",
                     exp_q.size(), done_cnt, n_push);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
